imem_sync_loader: RTL
=====================

# imem_sync_loader

Parametrised, synchronous-read instruction memory for the pipelined core. It is word-addressed from a byte PC, registers the fetched word straight into the Decode stage, and honours fetch stall and decode flush. It also flags misaligned and out-of-range fetches, and exposes a handshaked loader port that reprograms the memory at run time with no initial-block images.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, ≥ 4.
- AW, $clog2(DEPTH): word-address width; derived, not overridden.
- NOP_WORD, 32'h00000013: bubble word (addi x0, x0, 0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PCF  in  32  fetch byte address.
- StallF  in  1  hold the current InstrD and fault.
- FlushD  in  1  replace the next InstrD with NOP_WORD.
- InstrD  out  32  registered fetched instruction.
- fault  out  1  registered; the fetch at InstrD was misaligned or out of range.
- ld_start  in  1  request to begin a program load.
- ld_valid  in  1  loader data valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks the final loader word.
- ld_ready  out  1  loader may transfer.
- busy  out  1  a load is in progress.
- ld_count  out  AW+1  words written by the current or most recent load.

## Operation
- FSM has two states: RUN (the reset state) and LOAD.
- RUN → LOAD on ld_start. The write pointer and ld_count clear to 0.
- LOAD: ld_ready=1 and busy=1. On each ld_valid&&ld_ready beat:
  - mem[ptr] ← ld_data.
  - ptr and ld_count both increment.
- LOAD → RUN after an accepted beat with ld_last, or after accepting the beat at ptr=DEPTH-1. The memory is full at that point, the pointer does not wrap, and further data is not accepted.
- ld_start is ignored while in LOAD.
- Fetch in RUN, when StallF=0:
  - Word index is PCF[AW+1:2].
  - misaligned = PCF[1:0]≠0.
  - out_of_range = PCF[31:AW+2]≠0.
  - Registered result, in priority order:
    - FlushD → InstrD=NOP_WORD, fault=0.
    - Otherwise, misaligned or out_of_range → InstrD=NOP_WORD, fault=1.
    - Otherwise → InstrD=mem[index], fault=0.
- StallF=1 without FlushD: InstrD and fault hold.
- StallF=1 with FlushD=1: the flush wins.
- Fetch in LOAD: InstrD=NOP_WORD and fault=0 every cycle, regardless of StallF, FlushD and PCF.
- Memory contents are not changed by reset. Before the first load, contents are undefined (X in simulation).

## Timing
- Read latency is 1 cycle. PCF sampled at edge n appears on InstrD after edge n.
- A write at edge n is visible to a fetch sampled at edge n+1 or later. No read and write collide, because fetch is suppressed in LOAD.
- Values after reset: InstrD=NOP_WORD, fault=0, ld_ready=0, busy=0, ld_count=0, state=RUN.
- Reset mid-load: the FSM returns to RUN and ld_count clears. Words already written persist.
- ld_ready is a registered state decode: it rises the cycle after ld_start is sampled and falls the cycle after the terminating beat.
- ld_count saturates at DEPTH.

## Structure
- Package imem_pkg holds the FSM state enum (RUN, LOAD) and the NOP_WORD constant.
- Single module. The loader FSM is small enough to stay inline, with no sub-module.
- The storage array is an inferred synchronous RAM: one write port and one registered read port.

## Test plan
- Reset with PCF=0 → InstrD=0x00000013, fault=0, busy=0, ld_ready=0.
- Load ld_data 0x00120213 then 0x00108093 with ld_last on the second beat → ld_count=2 and busy drops. Then PCF=0 → InstrD=0x00120213, and PCF=4 → InstrD=0x00108093, each one cycle after PCF is presented.
- PCF=6 → InstrD=NOP_WORD, fault=1. PCF=DEPTH*4 → InstrD=NOP_WORD, fault=1.
- StallF=1 while PCF changes from 0 to 4 → InstrD holds its old value. Assert FlushD during the stall → InstrD=NOP_WORD, fault=0.
- Load DEPTH words without ld_last → FSM returns to RUN after word DEPTH-1, ld_count=DEPTH, and ld_ready=0 afterwards.
- Assert reset after 3 load beats → busy=0 and ld_count=0, and a fetch at PCF=8 returns the third loaded word.

Source files
------------

// File: rtl/imem_sync_loader_pkg.sv
// Shared types and constants for the instruction memory and its loader.
// The loader FSM state and the bubble instruction live here.
package imem_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_sync_loader_if.sv
// Loader handshake bundle: the host drives words in, the memory reports progress.
interface imem_sync_loader_if #(
   parameter int DEPTH = 256
);

   localparam int AW = $clog2(DEPTH);

   logic          ld_start;
   logic          ld_valid;
   logic [31:0]   ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          busy;
   logic [AW:0]   ld_count;

   modport master (
      output ld_start, ld_valid, ld_data, ld_last,
      input  ld_ready, busy, ld_count
   );

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last,
      output ld_ready, busy, ld_count
   );

endinterface

// File: rtl/imem_sync_loader.sv
// Word-addressed instruction RAM with a registered read into Decode and a
// handshaked run-time loader that takes the fetch path offline while it writes.
module imem_sync_loader #(
   parameter int          DEPTH    = 256,
   parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         PCF,
   input  logic                StallF,
   input  logic                FlushD,
   output logic [31:0]         InstrD,
   output logic                fault,
   imem_sync_loader_if.slave   ld
);

   import imem_pkg::state_t;
   import imem_pkg::RUN;
   import imem_pkg::LOAD;

   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW-1:0]   LAST_PTR   = AW'(DEPTH - 1);
   localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

   state_t          state;
   logic [AW-1:0]   ptr;
   logic [31:0]     mem [DEPTH];

   logic [AW-1:0]   index;
   logic            misaligned;
   logic            out_of_range;
   logic            wr_en;

   assign index        = PCF[AW+1:2];
   assign misaligned   = |PCF[1:0];
   assign out_of_range = |PCF[31:AW+2];
   assign wr_en        = ld.ld_valid && ld.ld_ready;

   // NOTE: the storage array has no reset so it maps onto a plain RAM macro;
   // its contents survive a reset and are only changed by the loader.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr] <= ld.ld_data;
      end
   end

   // NOTE: every register below uses <= so all of them sample the same
   // pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         ptr         <= '0;
         ld.ld_count <= '0;
         ld.ld_ready <= 1'b0;
         ld.busy     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ld.ld_start) begin
                  state       <= LOAD;
                  ptr         <= '0;
                  ld.ld_count <= '0;
                  ld.ld_ready <= 1'b1;
                  ld.busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (wr_en) begin
                  if (ld.ld_count != FULL_COUNT) begin
                     ld.ld_count <= ld.ld_count + 1'b1;
                  end
                  // The last slot ends the load so the pointer never wraps.
                  if (ld.ld_last || ptr == LAST_PTR) begin
                     state       <= RUN;
                     ld.ld_ready <= 1'b0;
                     ld.busy     <= 1'b0;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Registered read port; a flush beats a stall, and loading forces bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         InstrD <= NOP_WORD;
         fault  <= 1'b0;
      end else if (state == LOAD || FlushD) begin
         InstrD <= NOP_WORD;
         fault  <= 1'b0;
      end else if (!StallF) begin
         if (misaligned || out_of_range) begin
            InstrD <= NOP_WORD;
            fault  <= 1'b1;
         end else begin
            InstrD <= mem[index];
            fault  <= 1'b0;
         end
      end
   end

endmodule
